// File: rtl/mc_control_if.sv
// mc_control_if: opcode/handshake inputs and datapath control outputs of the multi-cycle controller
interface mc_control_if #(
    parameter int CNT_W = 32
);
    logic [6:0]       opcode;
    logic             mem_ready;
    logic             branch_taken;
    logic             pc_write;
    logic             pc_src;
    logic             ir_write;
    logic             mem_read;
    logic             mem_write;
    logic             reg_write;
    logic             alu_src;
    logic             branch;
    logic [1:0]       mem_to_reg;
    logic [2:0]       state;
    logic             illegal;
    logic             timeout;
    logic [CNT_W-1:0] instret;

    modport master (
        output opcode, mem_ready, branch_taken,
        input  pc_write, pc_src, ir_write, mem_read, mem_write, reg_write, alu_src, branch,
        input  mem_to_reg, state, illegal, timeout, instret
    );

    modport slave (
        input  opcode, mem_ready, branch_taken,
        output pc_write, pc_src, ir_write, mem_read, mem_write, reg_write, alu_src, branch,
        output mem_to_reg, state, illegal, timeout, instret
    );
endinterface

// File: rtl/mc_control.sv
// mc_control: multi-cycle RV32I control FSM with memory wait timeout, sticky traps and retired-instruction counter
module mc_control #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input logic         clk,
    input logic         rst,
    mc_control_if.slave bus
);
    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd5
    } state_t;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_L    = 7'b0000011;
    localparam logic [6:0] OP_S    = 7'b0100011;
    localparam logic [6:0] OP_B    = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    state_t           r_state;
    state_t           w_next;
    logic [6:0]       r_op;
    logic [7:0]       r_cnt;
    logic             r_illegal;
    logic             r_timeout;
    logic [CNT_W-1:0] r_instret;
    logic             w_legal;
    logic             w_wait;
    logic             w_to;
    logic             w_ld;
    logic             w_pc_write;
    logic             w_pc_src;
    logic             w_ir_write;
    logic             w_mem_read;
    logic             w_mem_write;
    logic             w_reg_write;
    logic             w_alu_src;
    logic             w_branch;
    logic [1:0]       w_m2r;

    assign w_legal = bus.opcode inside {OP_R, OP_I, OP_L, OP_S, OP_B, OP_JAL, OP_JALR};
    assign w_wait  = (r_state == FETCH || r_state == MEM) && !bus.mem_ready;
    assign w_to    = w_wait && r_cnt == 8'(MEM_TIMEOUT - 1);
    assign w_ld    = r_op == OP_L;

    // next state and datapath controls from current state, latched opcode and handshakes
    always_comb begin
        w_next      = r_state;
        w_pc_write  = 1'b0;
        w_pc_src    = 1'b0;
        w_ir_write  = 1'b0;
        w_mem_read  = 1'b0;
        w_mem_write = 1'b0;
        w_reg_write = 1'b0;
        w_alu_src   = 1'b0;
        w_branch    = 1'b0;
        w_m2r       = 2'b00;
        case (r_state)
            FETCH: begin
                w_mem_read = 1'b1;
                w_ir_write = bus.mem_ready;
                w_pc_write = bus.mem_ready;
                w_next     = bus.mem_ready ? DECODE : w_to ? TRAP : FETCH;
            end
            DECODE: w_next = w_legal ? EXEC : TRAP;
            EXEC: begin
                w_alu_src   = r_op inside {OP_I, OP_L, OP_S, OP_JALR};
                w_branch    = r_op inside {OP_B, OP_JAL, OP_JALR};
                w_pc_src    = r_op inside {OP_B, OP_JAL, OP_JALR};
                w_pc_write  = (r_op == OP_B) ? bus.branch_taken : r_op inside {OP_JAL, OP_JALR};
                w_reg_write = r_op inside {OP_JAL, OP_JALR};
                w_m2r       = (r_op == OP_JAL) ? 2'b10 : (r_op == OP_JALR) ? 2'b11 : 2'b00;
                w_next      = (r_op inside {OP_R, OP_I}) ? WB : (r_op inside {OP_L, OP_S}) ? MEM : FETCH;
            end
            MEM: begin
                w_mem_read  = w_ld;
                w_mem_write = !w_ld;
                w_alu_src   = 1'b1;
                w_next      = bus.mem_ready ? (w_ld ? WB : FETCH) : w_to ? TRAP : MEM;
            end
            WB: begin
                w_reg_write = 1'b1;
                w_m2r       = w_ld ? 2'b01 : 2'b00;
                w_next      = FETCH;
            end
            default: w_next = TRAP;
        endcase
    end

    assign bus.pc_write   = w_pc_write & !rst;
    assign bus.pc_src     = w_pc_src & !rst;
    assign bus.ir_write   = w_ir_write & !rst;
    assign bus.mem_read   = w_mem_read & !rst;
    assign bus.mem_write  = w_mem_write & !rst;
    assign bus.reg_write  = w_reg_write & !rst;
    assign bus.alu_src    = w_alu_src & !rst;
    assign bus.branch     = w_branch & !rst;
    assign bus.mem_to_reg = rst ? 2'b00 : w_m2r;
    assign bus.state      = r_state;
    assign bus.illegal    = r_illegal;
    assign bus.timeout    = r_timeout;
    assign bus.instret    = r_instret;

    // state, latched opcode, wait counter, sticky trap causes and retire counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= FETCH;
            r_op      <= 7'd0;
            r_cnt     <= 8'd0;
            r_illegal <= 1'b0;
            r_timeout <= 1'b0;
            r_instret <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == DECODE) r_op <= bus.opcode;
            r_cnt <= (w_next != r_state) ? 8'd0 : w_wait ? r_cnt + 8'd1 : r_cnt;
            if (r_state == DECODE && !w_legal) r_illegal <= 1'b1;
            if (w_to) r_timeout <= 1'b1;
            if (w_next == FETCH && r_state inside {EXEC, MEM, WB}) r_instret <= r_instret + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_mc_control.sv
// tb_mc_control: directed and randomized instruction sequences checked against a per-instruction phase model
module tb_mc_control;
    localparam int CW = 4;
    localparam int TO = 4;
    localparam logic [6:0] OPS [7] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                                       7'b1100011, 7'b1101111, 7'b1100111};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mc_control_if #(.CNT_W(CW)) bus();
    mc_control #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [2:0] st;
        logic       rdy;
        logic [9:0] o;
    } step_t;

    step_t q[$];
    int tests = 0;
    int fails = 0;
    int exp_ret = 0;

    function automatic logic [9:0] dv();
        return {bus.pc_write, bus.pc_src, bus.ir_write, bus.mem_read, bus.mem_write,
                bus.reg_write, bus.alu_src, bus.branch, bus.mem_to_reg};
    endfunction

    function automatic logic [9:0] ov(input logic pw, ps, ir, mr, mw, rw, as, br, input logic [1:0] m);
        return {pw, ps, ir, mr, mw, rw, as, br, m};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic add(input logic [2:0] st, input logic rdy, input logic [9:0] o);
        q.push_back('{st: st, rdy: rdy, o: o});
    endtask

    // expected cycle-by-cycle phases of one instruction: class c (R,I,L,S,B,JAL,JALR), taken t, fetch/mem wait counts
    task automatic build(input int c, input logic t, input int wf, input int wm);
        repeat (wf) add(3'd0, 1'b0, ov(0, 0, 0, 1, 0, 0, 0, 0, 2'd0));
        add(3'd0, 1'b1, ov(1, 0, 1, 1, 0, 0, 0, 0, 2'd0));
        add(3'd1, 1'($urandom), ov(0, 0, 0, 0, 0, 0, 0, 0, 2'd0));
        case (c)
            0: begin
                add(3'd2, 1'($urandom), ov(0, 0, 0, 0, 0, 0, 0, 0, 2'd0));
                add(3'd4, 1'($urandom), ov(0, 0, 0, 0, 0, 1, 0, 0, 2'd0));
            end
            1: begin
                add(3'd2, 1'($urandom), ov(0, 0, 0, 0, 0, 0, 1, 0, 2'd0));
                add(3'd4, 1'($urandom), ov(0, 0, 0, 0, 0, 1, 0, 0, 2'd0));
            end
            2: begin
                add(3'd2, 1'($urandom), ov(0, 0, 0, 0, 0, 0, 1, 0, 2'd0));
                repeat (wm) add(3'd3, 1'b0, ov(0, 0, 0, 1, 0, 0, 1, 0, 2'd0));
                add(3'd3, 1'b1, ov(0, 0, 0, 1, 0, 0, 1, 0, 2'd0));
                add(3'd4, 1'($urandom), ov(0, 0, 0, 0, 0, 1, 0, 0, 2'd1));
            end
            3: begin
                add(3'd2, 1'($urandom), ov(0, 0, 0, 0, 0, 0, 1, 0, 2'd0));
                repeat (wm) add(3'd3, 1'b0, ov(0, 0, 0, 0, 1, 0, 1, 0, 2'd0));
                add(3'd3, 1'b1, ov(0, 0, 0, 0, 1, 0, 1, 0, 2'd0));
            end
            4: add(3'd2, 1'($urandom), ov(t, 1, 0, 0, 0, 0, 0, 1, 2'd0));
            5: add(3'd2, 1'($urandom), ov(1, 1, 0, 0, 0, 1, 0, 1, 2'd2));
            default: add(3'd2, 1'($urandom), ov(1, 1, 0, 0, 0, 1, 1, 1, 2'd3));
        endcase
    endtask

    task automatic run_q(input logic [6:0] op, input logic t, input int n, input string tag);
        int m;
        m = (n < 0) ? q.size() : n;
        bus.opcode = op;
        for (int i = 0; i < m; i++) begin
            bus.mem_ready = q[i].rdy;
            bus.branch_taken = (q[i].st == 3'd2) ? t : 1'($urandom);
            @(negedge clk);
            chk($sformatf("%s_state%0d", tag, i), 32'(bus.state), 32'(q[i].st));
            chk($sformatf("%s_outs%0d", tag, i), 32'(dv()), 32'(q[i].o));
            @(posedge clk);
            #1;
            if (q[i].st == 3'd1) bus.opcode = 7'($urandom);
        end
    endtask

    task automatic run_instr(input int c, input logic t, input int wf, input int wm, input int n, input string tag);
        q.delete();
        build(c, t, wf, wm);
        run_q(OPS[c], t, n, tag);
        if (n < 0) begin
            exp_ret++;
            chk({tag, "_instret"}, 32'(bus.instret), 32'(exp_ret % (1 << CW)));
            chk({tag, "_end"}, 32'(bus.state), 32'd0);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_ret = 0;
    endtask

    initial begin
        bus.opcode = 7'd0;
        bus.mem_ready = 1'b1;
        bus.branch_taken = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_outs", 32'(dv()), 32'd0);
        chk("rst_state", 32'(bus.state), 32'd0);
        chk("rst_instret", 32'(bus.instret), 32'd0);
        chk("rst_flags", 32'({bus.illegal, bus.timeout}), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_instr(0, 1'b0, 0, 0, -1, "r_type");
        run_instr(2, 1'b0, 0, 3, -1, "load_wait3");
        run_instr(4, 1'b0, 0, 0, -1, "br_nt");
        run_instr(4, 1'b1, 0, 0, -1, "br_t");
        run_instr(6, 1'b0, 0, 0, -1, "jalr");
        run_instr(3, 1'b0, 3, 3, -1, "store_waits");
        for (int k = 0; k < 40; k++)
            run_instr($urandom_range(0, 6), 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), -1,
                      $sformatf("rnd%0d", k));
        run_instr(2, 1'b0, 1, 3, 4, "abort");
        bus.mem_ready = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        chk("abort_rst_outs", 32'(dv()), 32'd0);
        chk("abort_rst_state", 32'(bus.state), 32'd3);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_ret = 0;
        chk("abort_state", 32'(bus.state), 32'd0);
        chk("abort_instret", 32'(bus.instret), 32'd0);
        q.delete();
        add(3'd0, 1'b1, ov(1, 0, 1, 1, 0, 0, 0, 0, 2'd0));
        add(3'd1, 1'b1, ov(0, 0, 0, 0, 0, 0, 0, 0, 2'd0));
        run_q(7'h7f, 1'b0, -1, "illegal");
        for (int k = 0; k < 20; k++) begin
            bus.mem_ready = 1'($urandom);
            bus.branch_taken = 1'($urandom);
            bus.opcode = 7'($urandom);
            @(negedge clk);
            chk("trap_state", 32'(bus.state), 32'd5);
            chk("trap_flags", 32'({bus.illegal, bus.timeout}), 32'b10);
            chk("trap_outs", 32'(dv()), 32'd0);
            chk("trap_instret", 32'(bus.instret), 32'd0);
            @(posedge clk);
            #1;
        end
        do_reset();
        chk("post_trap_state", 32'(bus.state), 32'd0);
        chk("post_trap_flags", 32'({bus.illegal, bus.timeout}), 32'd0);
        q.delete();
        repeat (TO) add(3'd0, 1'b0, ov(0, 0, 0, 1, 0, 0, 0, 0, 2'd0));
        run_q(7'd0, 1'b0, -1, "fetch_to");
        bus.mem_ready = 1'b1;
        @(negedge clk);
        chk("to_state", 32'(bus.state), 32'd5);
        chk("to_flags", 32'({bus.illegal, bus.timeout}), 32'b01);
        chk("to_outs", 32'(dv()), 32'd0);
        @(posedge clk);
        #1;
        do_reset();
        run_instr(1, 1'b0, TO - 1, 0, -1, "fetch_edge");
        run_instr(2, 1'b0, 0, TO, 4 + TO - 1, "mem_to");
        bus.mem_ready = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("mem_to_state", 32'(bus.state), 32'd5);
        chk("mem_to_flags", 32'({bus.illegal, bus.timeout}), 32'b01);
        chk("mem_to_instret", 32'(bus.instret), 32'(exp_ret));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
